// File: rtl/nnrv_mem_arb.sv
// Two-requester arbiter (IF fetch vs MEM load/store) for a single-port synchronous-read RAM.
// Optional IF anti-starvation fairness counter: define NNRV_MEM_ARB_FAIR_EN.
module nnrv_mem_arb #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  output logic                  o_if_gnt,
  output logic                  o_if_stall,
  output logic                  o_if_rvalid,
  output logic [XLEN-1:0]       o_if_rdata,
  input  logic                  i_mem_req,
  input  logic                  i_mem_we,
  input  logic [ADDR_WIDTH-1:0] i_mem_addr,
  input  logic [XLEN-1:0]       i_mem_wdata,
  input  logic [3:0]            i_mem_mask,
  output logic                  o_mem_gnt,
  output logic                  o_mem_rvalid,
  output logic [XLEN-1:0]       o_mem_rdata,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic                  o_ram_rd_en,
  output logic                  o_ram_wr_en,
  output logic [3:0]            o_ram_mask,
  output logic [XLEN-1:0]       o_ram_wdata,
  input  logic [XLEN-1:0]       i_ram_rd_data
);

  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_IF_RD,
    OWN_MEM_RD
  } owner_e;

  // A zero threshold would leave the fairness counter with no bits.
  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("nnrv_mem_arb: STARVE_MAX must be at least 1");
  end

  owner_e owner_q;
  logic   if_prio;
  logic   if_gnt;
  logic   mem_gnt;

`ifdef NNRV_MEM_ARB_FAIR_EN
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_q;

  assign if_prio = (starve_q == CNT_W'(STARVE_MAX));

  // Counts MEM wins over a waiting IF; any IF win or IF going quiet restarts the run.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_q <= '0;
    end else if (if_gnt || !i_if_req) begin
      starve_q <= '0;
    end else if (mem_gnt && !if_prio) begin
      starve_q <= starve_q + 1'b1;
    end
  end
`else
  assign if_prio = 1'b0;
`endif

  // Grants are gated by reset so nothing reaches the RAM while reset is held.
  assign mem_gnt    = i_rst_n & i_mem_req & ~(i_if_req & if_prio);
  assign if_gnt     = i_rst_n & i_if_req & ~mem_gnt;
  assign o_mem_gnt  = mem_gnt;
  assign o_if_gnt   = if_gnt;
  assign o_if_stall = i_rst_n & i_if_req & ~if_gnt;

  assign o_ram_rd_en = if_gnt | (mem_gnt & ~i_mem_we);
  assign o_ram_wr_en = mem_gnt & i_mem_we;
  assign o_ram_addr  = mem_gnt ? i_mem_addr :
                       if_gnt  ? i_if_addr  : '0;
  assign o_ram_mask  = mem_gnt ? i_mem_mask :
                       if_gnt  ? 4'b1111    : 4'b0000;
  assign o_ram_wdata = i_mem_wdata;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner_q <= OWN_IDLE;
    end else if (if_gnt) begin
      owner_q <= OWN_IF_RD;
    end else if (mem_gnt && !i_mem_we) begin
      owner_q <= OWN_MEM_RD;
    end else begin
      owner_q <= OWN_IDLE;
    end
  end

  assign o_if_rvalid  = (owner_q == OWN_IF_RD);
  assign o_mem_rvalid = (owner_q == OWN_MEM_RD);
  assign o_if_rdata   = o_if_rvalid  ? i_ram_rd_data : '0;
  assign o_mem_rdata  = o_mem_rvalid ? i_ram_rd_data : '0;

endmodule
